// File: rtl/bram_c_reader_if.sv
// Row stream from bram_c_reader to its consumer: valid/ready with an end-of-drain marker.
interface bram_c_reader_if #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4
);
  logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/bram_c_reader.sv
// Drains result rows from BRAM C port 0 into a small FIFO and streams them out.
// Reads are only issued when FIFO occupancy plus the in-flight read leaves room.
module bram_c_reader #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [7:0]                     num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic                           bram_en,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata,
  bram_c_reader_if.master                out_if
);
  localparam int WORD_W = MAT_MUL_SIZE * DWIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [AWIDTH-1:0] STRIDE  = AWIDTH'(MAT_MUL_SIZE);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t             state_r;
  logic [AWIDTH-1:0]  addr_r;
  logic [AWIDTH-1:0]  last_addr_r;
  logic [7:0]         rows_left_r;
  logic [7:0]         beats_left_r;
  logic               inflight_r;
  logic               busy_r;
  logic               done_r;
  logic [WORD_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic issue_s;
  logic push_s;
  logic pop_s;
  logic out_valid_s;

  // The in-flight read already owns a FIFO slot, so backpressure stalls issue immediately.
  assign issue_s     = (state_r == READ) && ((count_r + CNT_W'(inflight_r)) < DEPTH_C);
  assign push_s      = inflight_r;
  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign pop_s       = out_valid_s && out_if.out_ready;

  assign bram_en          = issue_s;
  assign busy             = busy_r;
  assign done             = done_r;
  assign out_if.out_valid = out_valid_s;
  assign out_if.out_last  = out_valid_s && (beats_left_r == 8'd1);

  // Address bus shows the live address while issuing and holds the previous one otherwise.
  always_comb begin
    bram_addr = last_addr_r;
    if (issue_s) begin
      bram_addr = addr_r;
    end else begin
      bram_addr = last_addr_r;
    end
  end

  // FIFO head is gated so the stream reads zero whenever nothing is valid.
  always_comb begin
    out_if.out_data = {WORD_W{1'b0}};
    if (out_valid_s) begin
      out_if.out_data = mem_r[rd_ptr_r];
    end else begin
      out_if.out_data = {WORD_W{1'b0}};
    end
  end

  // Drain sequencer: address walk, row/beat accounting and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= {AWIDTH{1'b0}};
      last_addr_r  <= {AWIDTH{1'b0}};
      rows_left_r  <= 8'd0;
      beats_left_r <= 8'd0;
      inflight_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (pop_s) begin
        beats_left_r <= beats_left_r - 8'd1;
      end
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (num_rows != 8'd0) begin
              addr_r       <= base_addr;
              rows_left_r  <= num_rows;
              beats_left_r <= num_rows;
              busy_r       <= 1'b1;
              state_r      <= READ;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        READ: begin
          if (issue_s) begin
            addr_r      <= addr_r + STRIDE;
            last_addr_r <= addr_r;
            rows_left_r <= rows_left_r - 8'd1;
            if (rows_left_r == 8'd1) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish on the final pop itself so done lands the very next cycle.
          if ((beats_left_r == 8'd0) || ((beats_left_r == 8'd1) && pop_s)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage captures the BRAM word the cycle after its read was issued.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bram_rdata;
    end
  end
endmodule

// File: tb/tb_bram_c_reader.sv
// Bench for bram_c_reader: BRAM model, vector table of drains, random backpressure,
// reset-mid-drain sequence; expectations come from base + i*stride over the BRAM image.
module tb_bram_c_reader;
  localparam int AW    = 10;
  localparam int MMS   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [7:0]  num_rows;
  logic        busy, done, bram_en;
  logic [9:0]  bram_addr;
  logic [31:0] bram_rdata;
  logic [31:0] bmem [0:1023];

  int checks = 0;
  int failures = 0;

  bram_c_reader_if #(.DWIDTH(8), .MAT_MUL_SIZE(MMS)) out_if ();

  bram_c_reader #(.AWIDTH(AW), .DWIDTH(8), .MAT_MUL_SIZE(MMS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_rdata(bram_rdata), .out_if(out_if)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM read port.
  always @(posedge clk) begin
    if (bram_en) bram_rdata <= bmem[bram_addr];
  end

  typedef struct {
    logic [9:0] base;
    int n;
    int mode;       // 0: ready=1, 1: ready=0 through cycle 10, 2: random ready
    int exp_done;   // expected done cycle, -1 = not fixed
    int exp_iss10;  // reads issued by end of cycle 10, -1 = not checked
    int restart;    // cycle for a stray start pulse, 0 = none
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_addr(input logic [9:0] b, input int i);
    int a;
    a = (int'(b) + i * MMS) % 1024;
    return a[9:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " bram_en"}, bram_en, 0);
    chk({tag, " bram_addr"}, bram_addr, 0);
    chk({tag, " out_valid"}, out_if.out_valid, 0);
    chk({tag, " out_last"}, out_if.out_last, 0);
    chk({tag, " out_data"}, out_if.out_data, 0);
  endtask

  task automatic run_drain(input vec_t v, input string tag);
    int issued = 0, popped = 0, done_cyc = -1, first_en = -1, first_val = -1;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; num_rows = v.n[7:0];
    out_if.out_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == v.restart);
      if (start) begin base_addr = 10'h200; num_rows = 8'd9; end
      case (v.mode)
        0: out_if.out_ready = 1'b1;
        1: out_if.out_ready = (cyc > 10);
        default: out_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (bram_en) begin
        if (first_en < 0) first_en = cyc;
        chk({tag, " occupancy"}, (issued - popped) <= DEPTH, 1);
        chk({tag, " extra read"}, issued < v.n, 1);
        chk({tag, " bram_addr"}, bram_addr, exp_addr(v.base, issued));
        issued++;
      end
      if (out_if.out_valid) begin
        if (first_val < 0) first_val = cyc;
        chk({tag, " extra row"}, popped < v.n, 1);
        chk({tag, " out_data"}, out_if.out_data, bmem[exp_addr(v.base, popped)]);
        chk({tag, " out_last"}, out_if.out_last, popped == v.n - 1);
        if (out_if.out_ready) popped++;
      end
      if (done) begin
        done_cyc = cyc;
        chk({tag, " busy at done"}, busy, 0);
      end else begin
        chk({tag, " busy"}, busy, v.n > 0);
      end
      if (cyc == 10 && v.exp_iss10 >= 0) chk({tag, " reads before stall"}, issued, v.exp_iss10);
    end
    chk({tag, " done seen (timeout)"}, done_cyc >= 0, 1);
    chk({tag, " reads"}, issued, v.n);
    chk({tag, " rows"}, popped, v.n);
    if (v.exp_done >= 0) chk({tag, " done cycle"}, done_cyc, v.exp_done);
    if (v.n > 0) begin
      chk({tag, " first bram_en cycle"}, first_en, 1);
      chk({tag, " first out_valid cycle"}, first_val, 3);
    end
    @(posedge clk); #2;
    chk({tag, " done pulse width"}, done, 0);
    chk({tag, " busy after done"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
    vecs[0] = '{10'h010, 4,   0, 7,  -1, 0};
    vecs[1] = '{10'h010, 4,   1, 15, -1, 0};
    vecs[2] = '{10'h100, 8,   1, -1, DEPTH, 0};
    vecs[3] = '{10'h3FC, 3,   0, 6,  -1, 0};
    vecs[4] = '{10'h000, 0,   0, 1,  -1, 0};
    vecs[5] = '{10'h020, 4,   0, 7,  -1, 2};
    vecs[6] = '{10'h040, 255, 2, -1, -1, 0};

    reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; out_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      run_drain(vecs[i], $sformatf("v%0d", i));
      repeat (2) @(posedge clk);
    end

    // Reset in the middle of an 8-row drain after exactly two rows were taken.
    begin
      int popped = 0;
      @(negedge clk);
      start = 1'b1; base_addr = 10'h080; num_rows = 8'd8; out_if.out_ready = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (cyc == 5) reset = 1'b1;
        #1;
        if (cyc < 5 && out_if.out_valid && out_if.out_ready) begin
          chk("mid out_data", out_if.out_data, bmem[exp_addr(10'h080, popped)]);
          popped++;
        end
      end
      chk("mid pops before reset", popped, 2);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk_reset_vals("mid reset");
      @(posedge clk); #2;
      chk("post reset out_valid", out_if.out_valid, 0);
      chk("post reset bram_en", bram_en, 0);
      run_drain('{10'h1F0, 5, 0, 8, -1, 0}, "after reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
